song_sequencer: RTL and testbench
=================================

// Module: song_sequencer
// PURPOSE
//  Parametrised successor to the fixed 4-song/32-note reader. Walks a song ROM
//  and issues {note,duration} to the note player one entry at a time. Adds
//  configurable song count, depth and field widths, loop mode, an end-of-song
//  marker, and restart on song change. Sits between the top-level controls and
//  note_player, and drives an external synchronous song ROM.
// PARAMETERS
//  SONG_W  2  song select width; 2**SONG_W songs
//  IDX_W   5  note index width; 2**IDX_W entries per song
//  NOTE_W  6  note field width
//  DUR_W   6  duration field width
// PORTS
//  clk         in   1              system clock
//  reset       in   1              synchronous, active-high reset
//  play        in   1              1 = advance through song; 0 = pause issuing notes
//  loop        in   1              1 = wrap to entry 0 at end of song
//  song        in   SONG_W         song select, sampled every cycle
//  note_done   in   1              1-cycle pulse from note_player: current note finished
//  rom_addr    out  SONG_W+IDX_W   {song_latched, index}
//  rom_data    in   NOTE_W+DUR_W   {note, duration}, valid 1 cycle after rom_addr
//  note        out  NOTE_W         registered note of the current entry
//  duration    out  DUR_W          registered duration of the current entry
//  new_note    out  1              1-cycle pulse: note/duration are newly valid
//  song_done   out  1              1-cycle pulse: end of song reached
//  note_index  out  IDX_W          index of the entry being played
// BEHAVIOUR
//  Reset: state IDLE, index 0, song_latched = 0, note/duration/new_note/song_done
//   all 0. Reset in any state aborts the song with no song_done pulse.
//  States: IDLE, FETCH, WAIT_ROM, SEND, WAIT_DONE, STOPPED.
//  IDLE:     song_latched <= song, index <= 0 -> FETCH.
//  FETCH:    rom_addr presented -> WAIT_ROM. ROM read latency is exactly 1 cycle.
//  WAIT_ROM: capture rom_data into note/duration. If duration == 0, the entry is
//            an end marker: pulse song_done and go to END handling. Otherwise,
//            if play = 1 -> SEND, else hold in WAIT_ROM. The captured data is
//            retained while held.
//  SEND:     new_note = 1 for this cycle only -> WAIT_DONE.
//  WAIT_DONE: wait for note_done. On note_done:
//            - if index == 2**IDX_W-1, pulse song_done next cycle and go to END;
//            - otherwise index+1 -> FETCH.
//            play = 0 does not block note_done; the pause takes effect at the
//            next WAIT_ROM.
//  END:      if loop = 1, index <= 0 -> FETCH, with no idle gap beyond 1 cycle.
//            If loop = 0 -> STOPPED, keeping note/duration at their last values.
//  STOPPED:  leave on a rising edge of play (registered play_q) or on a song
//            change -> IDLE.
//  Song change: if song != song_latched in any state other than IDLE, go to
//   IDLE next cycle. The current note is abandoned, no song_done pulse is given,
//   and note_done for the abandoned note is ignored.
//  Simultaneous events: a song change has priority over note_done and over end
//   handling. A note_done that is not in WAIT_DONE is ignored.
//  Index arithmetic: IDX_W bits; the final entry never wraps implicitly. Only
//   END resets the index.
//  Latency: from IDLE, the first new_note comes 4 cycles later with play = 1
//   (IDLE, FETCH, WAIT_ROM, SEND). From note_done to the next new_note is 3
//   cycles.
//  song_done and new_note never assert in the same cycle.
// TESTING
//  1 Defaults; ROM song 1 full of dur=3; loop=0, play=1; pulse note_done 3 cyc
//    after each new_note -> 32 new_note pulses, index 0..31, one song_done,
//    then STOPPED and rom_addr stops changing.
//  2 Song 2 entry 5 dur=0 -> 5 new_notes (idx 0..4), song_done, no 6th new_note.
//  3 loop=1, song with marker at idx 3 -> new_note idx 0,1,2, song_done, then
//    idx 0 again within 4 cycles; 3 loops are checked.
//  4 play=0 during WAIT_DONE at idx 7 -> note_done accepted, idx 8 fetched, no
//    new_note until play=1; new_note comes 1 cycle after play rises, note=ROM[8].
//  5 Change song 0->3 at idx 10, in the same cycle as note_done -> no song_done,
//    next new_note is ROM[{3,0}], and index=0.
//  6 Reset in WAIT_DONE at idx 12 -> all outputs 0 the next cycle. After reset
//    is released, the first new_note is ROM[{0,0}] 4 cycles later.
//    Also: STOPPED + play 1->0->1 restarts the song at idx 0.

Source files
------------

// File: rtl/song_sequencer.sv
// ---------------------------------------------------------------------------
// song_sequencer
//
// Walks an external synchronous song ROM and hands {note, duration} pairs to
// the note player one entry at a time. It supports a configurable song count,
// song depth and field widths. It also provides loop mode, an end-of-song
// marker (an entry with duration 0), and a restart whenever the song select
// changes.
//
// Ports
//   clk            system clock
//   reset          synchronous, active-high reset
//   play_i         1 = keep issuing notes; 0 = pause at the next ROM fetch
//   loop_i         1 = wrap to entry 0 when the song ends
//   song_i         song select, sampled every cycle
//   note_done_i    1-cycle pulse from the note player: current note finished
//   rom_addr_o     {song_latched, index} ROM address
//   rom_data_i     {note, duration}; valid 1 cycle after rom_addr_o
//   note_o         registered note of the current entry
//   duration_o     registered duration of the current entry
//   new_note_o     1-cycle pulse: note_o/duration_o are newly valid
//   song_done_o    1-cycle pulse: end of song reached
//   note_index_o   index of the entry being played
// ---------------------------------------------------------------------------
module song_sequencer #(
  parameter int SONG_W = 2,
  parameter int IDX_W  = 5,
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      play_i,
  input  logic                      loop_i,
  input  logic [SONG_W-1:0]         song_i,
  input  logic                      note_done_i,
  output logic [SONG_W+IDX_W-1:0]   rom_addr_o,
  input  logic [NOTE_W+DUR_W-1:0]   rom_data_i,
  output logic [NOTE_W-1:0]         note_o,
  output logic [DUR_W-1:0]          duration_o,
  output logic                      new_note_o,
  output logic                      song_done_o,
  output logic [IDX_W-1:0]          note_index_o
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_ROM,
    SEND,
    WAIT_DONE,
    END,
    STOPPED
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    index_q, index_d;
  logic [SONG_W-1:0]   song_q,  song_d;
  logic [NOTE_W-1:0]   note_q,  note_d;
  logic [DUR_W-1:0]    dur_q,   dur_d;
  logic                play_q;

  logic [NOTE_W-1:0]   rom_note;
  logic [DUR_W-1:0]    rom_dur;
  logic                song_change;
  logic                play_rise;

  assign rom_note = rom_data_i[NOTE_W+DUR_W-1:DUR_W];
  assign rom_dur  = rom_data_i[DUR_W-1:0];

  // IDLE is the state that adopts a new song, so a mismatch there is not a change.
  assign song_change = (state_q != IDLE) && (song_i != song_q);
  assign play_rise   = play_i && !play_q;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    index_d = index_q;
    song_d  = song_q;
    note_d  = note_q;
    dur_d   = dur_q;

    if (song_change) begin
      // Song change outranks note_done and end handling; the current note is
      // abandoned without a song_done pulse.
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          song_d  = song_i;
          index_d = '0;
          state_d = FETCH;
        end
        FETCH: begin
          state_d = WAIT_ROM;
        end
        WAIT_ROM: begin
          // rom_addr_o is stable while holding here, so recapturing every cycle
          // keeps the same data.
          note_d = rom_note;
          dur_d  = rom_dur;
          if (rom_dur == '0) begin
            state_d = END;
          end else if (play_i) begin
            state_d = SEND;
          end
        end
        SEND: begin
          state_d = WAIT_DONE;
        end
        WAIT_DONE: begin
          if (note_done_i) begin
            if (index_q == LAST_IDX) begin
              state_d = END;
            end else begin
              index_d = index_q + IDX_W'(1);
              state_d = FETCH;
            end
          end
        end
        END: begin
          if (loop_i) begin
            index_d = '0;
            state_d = FETCH;
          end else begin
            state_d = STOPPED;
          end
        end
        STOPPED: begin
          if (play_rise) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the values from before the clock edge.
    if (reset) begin
      state_q <= IDLE;
      index_q <= '0;
      song_q  <= '0;
      note_q  <= '0;
      dur_q   <= '0;
      play_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      song_q  <= song_d;
      note_q  <= note_d;
      dur_q   <= dur_d;
      play_q  <= play_i;
    end
  end

  // The pulses are decoded from single states, so they can never overlap and
  // each lasts exactly one cycle.
  assign new_note_o   = (state_q == SEND);
  assign song_done_o  = (state_q == END);
  assign rom_addr_o   = {song_q, index_q};
  assign note_o       = note_q;
  assign duration_o   = dur_q;
  assign note_index_o = index_q;

endmodule

// File: tb/tb_song_sequencer.sv
// ---------------------------------------------------------------------------
// tb_song_sequencer
//
// Directed bench for song_sequencer with default parameters. A synchronous ROM
// model supplies the following contents:
//   song 0: note = idx+1,  dur 3, no marker
//   song 1: note = 63-idx, dur 3, no marker
//   song 2: note = idx+10, dur 3, end marker at idx 5
//   song 3: note = idx+40, dur 3, end marker at idx 3
// Inputs change on the falling edge. Outputs are read on the falling edge.
// ---------------------------------------------------------------------------
module tb_song_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        play_i = 1'b0;
  logic        loop_i = 1'b0;
  logic [1:0]  song_i = '0;
  logic        note_done_i = 1'b0;
  logic [6:0]  rom_addr_o;
  logic [11:0] rom_data_i = '0;
  logic [5:0]  note_o;
  logic [5:0]  duration_o;
  logic        new_note_o;
  logic        song_done_o;
  logic [4:0]  note_index_o;

  int compared   = 0;
  int mismatched = 0;
  int nn_cnt     = 0;
  int sd_cnt     = 0;
  int overlap    = 0;

  logic [11:0] rom [128];

  always #5 clk = ~clk;

  song_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .play_i       (play_i),
    .loop_i       (loop_i),
    .song_i       (song_i),
    .note_done_i  (note_done_i),
    .rom_addr_o   (rom_addr_o),
    .rom_data_i   (rom_data_i),
    .note_o       (note_o),
    .duration_o   (duration_o),
    .new_note_o   (new_note_o),
    .song_done_o  (song_done_o),
    .note_index_o (note_index_o)
  );

  always @(posedge clk) rom_data_i <= rom[rom_addr_o];

  always @(negedge clk) begin
    if (new_note_o === 1'b1) nn_cnt++;
    if (song_done_o === 1'b1) sd_cnt++;
    if (new_note_o === 1'b1 && song_done_o === 1'b1) overlap++;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic hold_reset(input logic [1:0] s);
    song_i = s;
    reset  = 1'b1;
    tick();
    tick();
  endtask

  // Plays the note player's part: note_done 3 cycles after new_note.
  task automatic serve_note();
    repeat (3) tick();
    note_done_i = 1'b1;
    tick();
    note_done_i = 1'b0;
  endtask

  // Returns the number of falling edges until new_note is seen, or -1 on timeout.
  task automatic wait_new_note(input int budget, output int waited);
    waited = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (new_note_o === 1'b1) begin
        waited = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    hold_reset(2'd1);
    compared++;
    if ({note_o, duration_o, new_note_o, song_done_o, note_index_o, rom_addr_o} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: got note=%0d dur=%0d nn=%0d sd=%0d idx=%0d addr=%0d required all 0",
               note_o, duration_o, new_note_o, song_done_o, note_index_o, rom_addr_o);
    end
  endtask

  task automatic test_full_song();
    int w, sd0, nn0;
    play_i = 1'b1;
    loop_i = 1'b0;
    reset  = 1'b0;
    sd0 = sd_cnt;
    for (int k = 0; k < 32; k++) begin
      wait_new_note(20, w);
      compared++;
      if (w !== ((k == 0) ? 3 : 2)) begin
        mismatched++;
        $display("FAIL full_latency[%0d]: got %0d required %0d", k, w, (k == 0) ? 3 : 2);
      end
      compared++;
      if (note_index_o !== 5'(k) || note_o !== 6'(63 - k) || duration_o !== 6'd3) begin
        mismatched++;
        $display("FAIL full_entry[%0d]: got idx=%0d note=%0d dur=%0d required idx=%0d note=%0d dur=3",
                 k, note_index_o, note_o, duration_o, k, 63 - k);
      end
      serve_note();
    end
    nn0 = nn_cnt;
    repeat (10) tick();
    compared++;
    if (sd_cnt - sd0 !== 1 || nn_cnt - nn0 !== 0) begin
      mismatched++;
      $display("FAIL full_end: got song_done=%0d extra new_note=%0d required 1 and 0",
               sd_cnt - sd0, nn_cnt - nn0);
    end
    repeat (5) tick();
    compared++;
    if (rom_addr_o !== 7'd63 || nn_cnt - nn0 !== 0) begin
      mismatched++;
      $display("FAIL full_stopped: got addr=%0d new_note=%0d required addr=63 new_note=0",
               rom_addr_o, nn_cnt - nn0);
    end
  endtask

  task automatic test_end_marker();
    int w, sd0, nn0;
    sd0 = sd_cnt;
    song_i = 2'd2;
    for (int k = 0; k < 5; k++) begin
      wait_new_note(20, w);
      compared++;
      if (w !== ((k == 0) ? 4 : 2)) begin
        mismatched++;
        $display("FAIL marker_latency[%0d]: got %0d required %0d", k, w, (k == 0) ? 4 : 2);
      end
      compared++;
      if (note_index_o !== 5'(k) || note_o !== 6'(k + 10)) begin
        mismatched++;
        $display("FAIL marker_entry[%0d]: got idx=%0d note=%0d required idx=%0d note=%0d",
                 k, note_index_o, note_o, k, k + 10);
      end
      serve_note();
    end
    nn0 = nn_cnt;
    repeat (10) tick();
    compared++;
    if (sd_cnt - sd0 !== 1 || nn_cnt - nn0 !== 0 || note_index_o !== 5'd5) begin
      mismatched++;
      $display("FAIL marker_end: got song_done=%0d new_note=%0d idx=%0d required 1, 0, 5",
               sd_cnt - sd0, nn_cnt - nn0, note_index_o);
    end
  endtask

  task automatic test_stopped_restart();
    int w;
    play_i = 1'b0;
    tick();
    play_i = 1'b1;
    wait_new_note(20, w);
    compared++;
    if (w !== 4 || note_index_o !== 5'd0 || note_o !== 6'd10) begin
      mismatched++;
      $display("FAIL restart: got wait=%0d idx=%0d note=%0d required wait=4 idx=0 note=10",
               w, note_index_o, note_o);
    end
  endtask

  task automatic test_loop();
    int w, sd0;
    hold_reset(2'd3);
    loop_i = 1'b1;
    reset  = 1'b0;
    sd0 = sd_cnt;
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 3; k++) begin
        wait_new_note(20, w);
        compared++;
        if (w !== ((k > 0) ? 2 : (p == 0) ? 3 : 5) || note_index_o !== 5'(k) ||
            note_o !== 6'(k + 40)) begin
          mismatched++;
          $display("FAIL loop[%0d.%0d]: got wait=%0d idx=%0d note=%0d required wait=%0d idx=%0d note=%0d",
                   p, k, w, note_index_o, note_o, (k > 0) ? 2 : (p == 0) ? 3 : 5, k, k + 40);
        end
        if (k == 0) begin
          compared++;
          if (sd_cnt - sd0 !== p) begin
            mismatched++;
            $display("FAIL loop_done[%0d]: got %0d required %0d", p, sd_cnt - sd0, p);
          end
        end
        serve_note();
      end
    end
    wait_new_note(20, w);
    compared++;
    if (w !== 5 || note_index_o !== 5'd0 || sd_cnt - sd0 !== 3) begin
      mismatched++;
      $display("FAIL loop_third_wrap: got wait=%0d idx=%0d song_done=%0d required 5, 0, 3",
               w, note_index_o, sd_cnt - sd0);
    end
    loop_i = 1'b0;
  endtask

  task automatic test_pause();
    int w, nn0;
    hold_reset(2'd0);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      wait_new_note(20, w);
      compared++;
      if (w !== ((k == 0) ? 3 : 2) || note_index_o !== 5'(k) || note_o !== 6'(k + 1)) begin
        mismatched++;
        $display("FAIL pause_entry[%0d]: got wait=%0d idx=%0d note=%0d required wait=%0d idx=%0d note=%0d",
                 k, w, note_index_o, note_o, (k == 0) ? 3 : 2, k, k + 1);
      end
      if (k < 7) serve_note();
    end
    tick();
    play_i = 1'b0;
    tick();
    tick();
    note_done_i = 1'b1;
    tick();
    note_done_i = 1'b0;
    nn0 = nn_cnt;
    repeat (6) tick();
    compared++;
    if (nn_cnt - nn0 !== 0 || note_index_o !== 5'd8 || note_o !== 6'd9) begin
      mismatched++;
      $display("FAIL pause_hold: got new_note=%0d idx=%0d note=%0d required 0, 8, 9",
               nn_cnt - nn0, note_index_o, note_o);
    end
    play_i = 1'b1;
    wait_new_note(20, w);
    compared++;
    if (w !== 1 || note_index_o !== 5'd8 || note_o !== 6'd9 || duration_o !== 6'd3) begin
      mismatched++;
      $display("FAIL pause_resume: got wait=%0d idx=%0d note=%0d dur=%0d required 1, 8, 9, 3",
               w, note_index_o, note_o, duration_o);
    end
  endtask

  task automatic test_song_change();
    int w, sd0;
    serve_note();
    wait_new_note(20, w);
    serve_note();
    wait_new_note(20, w);
    compared++;
    if (note_index_o !== 5'd10) begin
      mismatched++;
      $display("FAIL change_pre_idx: got %0d required 10", note_index_o);
    end
    sd0 = sd_cnt;
    repeat (3) tick();
    note_done_i = 1'b1;
    song_i = 2'd3;
    tick();
    note_done_i = 1'b0;
    wait_new_note(20, w);
    compared++;
    if (w !== 3 || note_o !== 6'd40 || note_index_o !== 5'd0 || rom_addr_o !== 7'd96 ||
        sd_cnt - sd0 !== 0) begin
      mismatched++;
      $display("FAIL change: got wait=%0d note=%0d idx=%0d addr=%0d song_done=%0d required 3, 40, 0, 96, 0",
               w, note_o, note_index_o, rom_addr_o, sd_cnt - sd0);
    end
  endtask

  task automatic test_reset_mid_song();
    int w;
    hold_reset(2'd0);
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      wait_new_note(20, w);
      serve_note();
    end
    wait_new_note(20, w);
    compared++;
    if (note_index_o !== 5'd12 || note_o !== 6'd13) begin
      mismatched++;
      $display("FAIL midreset_pre: got idx=%0d note=%0d required 12, 13", note_index_o, note_o);
    end
    tick();
    reset = 1'b1;
    tick();
    compared++;
    if ({note_o, duration_o, new_note_o, song_done_o, note_index_o, rom_addr_o} !== '0) begin
      mismatched++;
      $display("FAIL midreset_outputs: got note=%0d dur=%0d nn=%0d sd=%0d idx=%0d addr=%0d required all 0",
               note_o, duration_o, new_note_o, song_done_o, note_index_o, rom_addr_o);
    end
    reset = 1'b0;
    wait_new_note(20, w);
    compared++;
    if (w !== 3 || note_o !== 6'd1 || note_index_o !== 5'd0) begin
      mismatched++;
      $display("FAIL midreset_restart: got wait=%0d note=%0d idx=%0d required 3, 1, 0",
               w, note_o, note_index_o);
    end
  endtask

  task automatic test_no_overlap();
    compared++;
    if (overlap !== 0) begin
      mismatched++;
      $display("FAIL pulse_overlap: got %0d cycles required 0", overlap);
    end
  endtask

  initial begin
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 32; i++) begin
        case (s)
          0:       rom[s*32+i] = {6'(i + 1), 6'd3};
          1:       rom[s*32+i] = {6'(63 - i), 6'd3};
          2:       rom[s*32+i] = (i == 5) ? {6'd50, 6'd0} : {6'(i + 10), 6'd3};
          default: rom[s*32+i] = (i == 3) ? {6'd50, 6'd0} : {6'(i + 40), 6'd3};
        endcase
      end
    end

    test_reset();
    test_full_song();
    test_end_marker();
    test_stopped_restart();
    test_loop();
    test_pause();
    test_song_change();
    test_reset_mid_song();
    test_no_overlap();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
